// File: rtl/uart_pkg.sv
// Shared constants for the oversampling UART receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DATA_W     = 8;
    localparam int IDX_W      = $clog2(DATA_W);
    localparam int MIN_PERIOD = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/uart_bitcnt.sv
// Bit-period down counter: half-period load on start edge, full-period reload per bit.
// Latency: zero strobe fires exactly N cycles after a load/reload that wrote N-1.
// Backpressure: none; load/reload are single-cycle strobes from the receiver FSM.
module uart_bitcnt
    import uart_pkg::*;
#(
    parameter int CMSB = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CMSB:0] div,
    input  logic          load,
    input  logic          reload,
    output logic          zero
);

    localparam logic [CMSB:0] PMIN = (CMSB+1)'(MIN_PERIOD);

    logic [CMSB:0] period;
    logic [CMSB:0] cnt;

    // Small divisors are clamped so the half-period sample point stays at least one cycle away.
    assign period = (div < PMIN) ? PMIN : div;

    // Counter holds cycles-to-sample minus one, so a strobe every P cycles needs a reload of P-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (period >> 1) - 1'b1;
        end else if (reload) begin
            cnt <= period - 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver with programmable bit period and a one-entry holding register with error flags.
// Latency: byte visible on rdata/full two cycles after the stop-bit sample point.
// Backpressure: none on the line; an unpopped byte is kept and later frames only raise ovr.
// Build option: define UART_RX_OS_PARITY_EN for 11-bit frames with even parity checking.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CMSB = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CMSB:0]     div,
    input  logic              clear,
    input  logic              rx,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              perr,
    output logic              ferr,
    output logic              ovr,
    output logic              busy
);

    logic              sync1;
    logic              sync2;
    logic              rx_prev;
    state_t            state;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              stop_bit;
    logic              commit_pend;
    logic              cnt_zero;
    logic              cnt_load;
    logic              cnt_reload;

    // Two-flop synchronizer plus one history flop for falling-edge detection; idle line is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    assign cnt_load   = (state == IDLE) && rx_prev && !sync2;
    assign cnt_reload = cnt_zero && ((state == START) || (state == DATA) || (state == PARITY));

    uart_bitcnt #(.CMSB(CMSB)) u_bitcnt (
        .clk    (clk),
        .rst    (rst),
        .div    (div),
        .load   (cnt_load),
        .reload (cnt_reload),
        .zero   (cnt_zero)
    );

`ifdef UART_RX_OS_PARITY_EN
    logic par_bit;
    logic perr_q;
    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

    // Frame FSM: samples each bit at its midpoint and flags a completed frame for commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_idx     <= '0;
            shreg       <= '0;
            stop_bit    <= 1'b1;
            commit_pend <= 1'b0;
`ifdef UART_RX_OS_PARITY_EN
            par_bit     <= 1'b0;
`endif
        end else if (clear) begin
            state       <= IDLE;
            commit_pend <= 1'b0;
        end else begin
            commit_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (cnt_load) state <= START;
                end
                START: begin
                    if (cnt_zero) begin
                        if (!sync2) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (cnt_zero) begin
                        shreg   <= {sync2, shreg[DATA_W-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_W'(DATA_W - 1)) begin
`ifdef UART_RX_OS_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_OS_PARITY_EN
                PARITY: begin
                    if (cnt_zero) begin
                        par_bit <= sync2;
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt_zero) begin
                        stop_bit    <= sync2;
                        commit_pend <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Holding register: commit if space (or freed this cycle by pop), else flag overrun; clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            full   <= 1'b0;
            ferr   <= 1'b0;
            ovr    <= 1'b0;
`ifdef UART_RX_OS_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else if (clear) begin
            full   <= 1'b0;
            ferr   <= 1'b0;
            ovr    <= 1'b0;
`ifdef UART_RX_OS_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else if (commit_pend) begin
            if (!full || pop) begin
                rdata  <= shreg;
                full   <= 1'b1;
                ferr   <= !stop_bit;
`ifdef UART_RX_OS_PARITY_EN
                perr_q <= par_bit ^ (^shreg);
`endif
            end else begin
                ovr <= 1'b1;
            end
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed frames plus randomized frames.
// Latency: a monitor compares each new byte against a queue filled when frames are sent.
// Backpressure: pops are issued only while the line is idle, so commits never race pops.
`timescale 1ns/1ps
module tb_uart_rx_os;

    localparam int CMSB = 12;
`ifdef UART_RX_OS_PARITY_EN
    localparam int NBITS  = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NBITS  = 10;
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [CMSB:0] div;
    logic          clear;
    logic          rx;
    logic          pop;
    logic [7:0]    rdata;
    logic          full;
    logic          perr;
    logic          ferr;
    logic          ovr;
    logic          busy;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t       exp_q[$];
    bit         m_full;
    bit         m_ovr;
    logic [7:0] m_rdata;
    int         tests = 0;
    int         fails = 0;
    int         cycle = 0;
    int         rise_cycle = -1;

    uart_rx_os #(.CMSB(CMSB)) dut (
        .clk   (clk),
        .rst   (rst),
        .div   (div),
        .clear (clear),
        .rx    (rx),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .perr  (perr),
        .ferr  (ferr),
        .ovr   (ovr),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: every new byte in the holding register must match the oldest expected frame.
    initial begin
        logic pf;
        pf = 1'b0;
        forever begin
            @(negedge clk);
            if (full && !pf) begin
                rise_cycle = cycle;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got rdata %02h, expected no new byte", rdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_rdata", 32'(rdata), 32'(e.data));
                    check("sb_perr", 32'(perr), 32'(e.perr));
                    check("sb_ferr", 32'(ferr), 32'(e.ferr));
                end
            end
            pf = full;
        end
    end

    // Reference behaviour of one received frame: accept into an empty register, else overrun.
    task automatic model_frame(input logic [7:0] d, input bit par_flip, input bit stop_bad);
        exp_t e;
        if (!m_full) begin
            e.data = d;
            e.perr = PAR_EN & par_flip;
            e.ferr = stop_bad;
            exp_q.push_back(e);
            m_full  = 1'b1;
            m_rdata = d;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic send_bits(input logic [7:0] d, input bit par_flip, input bit stop_bad, input int per);
        logic [10:0] bits;
        bits    = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (PAR_EN) begin
            bits[9]  = (^d) ^ par_flip;
            bits[10] = ~stop_bad;
        end else begin
            bits[9] = ~stop_bad;
        end
        for (int i = 0; i < NBITS; i++) begin
            rx = bits[i];
            repeat (per) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic frame(input logic [7:0] d, input bit par_flip, input bit stop_bad, input int per);
        model_frame(d, par_flip, stop_bad);
        send_bits(d, par_flip, stop_bad, per);
        repeat (2 * per + 8) @(negedge clk);
    endtask

    task automatic do_pop();
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        m_full = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_full"}, 32'(full), 32'(m_full));
        check({tag, "_ovr"}, 32'(ovr), 32'(m_ovr));
        check({tag, "_rdata"}, 32'(rdata), 32'(m_rdata));
    endtask

    initial begin
        int start_cycle;
        int lat;
        int dv;
        int per;
        logic [7:0] d;
        bit pf;
        bit sb;

        rst = 1'b1; clear = 1'b0; pop = 1'b0; rx = 1'b1; div = 13'd16;
        m_full = 1'b0; m_ovr = 1'b0; m_rdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_full", 32'(full), 0);
        check("rst_rdata", 32'(rdata), 0);
        check("rst_perr", 32'(perr), 0);
        check("rst_ferr", 32'(ferr), 0);
        check("rst_ovr", 32'(ovr), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Clean frame and timing of the full flag relative to the start edge.
        rise_cycle  = -1;
        start_cycle = cycle;
        frame(8'hA5, 1'b0, 1'b0, 16);
        lat = rise_cycle - start_cycle;
        check("a5_latency_in_window",
              32'((lat >= 16 * (NBITS - 1) + 8) && (lat <= 16 * (NBITS - 1) + 14)), 1);
        check_state("a5");
        do_pop();
        check("a5_pop_full", 32'(full), 0);

        // Corrupted parity bit (flag only present in the parity build).
        frame(8'h01, 1'b1, 1'b0, 16);
        check_state("par");
        do_pop();

        // Stop bit held low.
        frame(8'h3C, 1'b0, 1'b1, 16);
        check_state("stop");
        do_pop();

        // Two frames without pop: first byte kept, overrun set.
        frame(8'h11, 1'b0, 1'b0, 16);
        frame(8'h22, 1'b0, 1'b0, 16);
        check_state("ovr");
        do_pop();
        check_state("ovr_pop");
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_ovr = 1'b0;
        @(negedge clk);
        check_state("clear");

        // Short low glitch: receiver starts, rejects at the start sample, stays empty.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("glitch_busy_seen", 32'(busy), 1);
        repeat (30) @(negedge clk);
        check("glitch_busy_end", 32'(busy), 0);
        check("glitch_full", 32'(full), 0);

        // Randomized frames with random divisors; divisors below the minimum run at 4 clocks.
        for (int n = 0; n < 12; n++) begin
            d   = 8'($urandom);
            dv  = int'($urandom_range(0, 20));
            per = (dv < 4) ? 4 : dv;
            pf  = 1'($urandom_range(0, 1));
            sb  = ($urandom_range(0, 3) == 0);
            div = (CMSB+1)'(dv);
            frame(d, pf, sb, per);
            check_state("rand");
            do_pop();
        end

        // Divisor below minimum, then a reset in the middle of the next frame.
        div = 13'd2;
        frame(8'h5A, 1'b0, 1'b0, 4);
        check_state("div2");
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_full = 1'b0; m_ovr = 1'b0; m_rdata = 8'h00;
        exp_q.delete();
        repeat (60) @(negedge clk);
        check_state("midrst");
        check("midrst_busy", 32'(busy), 0);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter CMSB, default 12, giving the MSB index of the bit-period divisor.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port div, input, CMSB+1 bits: clk cycles per UART bit.
REQ-005 SHALL have port clear, input, 1 bit: synchronous abort and flag clear.
REQ-006 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-007 SHALL have port pop, input, 1 bit: one-cycle acknowledge that rdata has been consumed.
REQ-008 SHALL have port rdata, output, 8 bits: last accepted byte.
REQ-009 SHALL have port full, output, 1 bit: rdata holds an unconsumed byte.
REQ-010 SHALL have port perr, output, 1 bit: parity error of the frame in rdata.
REQ-011 SHALL have port ferr, output, 1 bit: framing error (stop bit low) of the frame in rdata.
REQ-012 SHALL have port ovr, output, 1 bit: sticky overrun flag.
REQ-013 SHALL have port busy, output, 1 bit: FSM not in IDLE.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1.
REQ-015 SHALL use frame format start(0), data[0..7] LSB first, parity = ^data (even), stop(1).
REQ-016 SHALL use effective period P = max(div, 4); any div below 4 is treated as 4.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL, in IDLE, move to START on a synced 1->0 edge and load the bit counter with P>>1.
REQ-019 SHALL, in START, sample at counter zero: 0 goes to DATA with counter reload P; 1 returns to IDLE as a glitch with no flags changed.
REQ-020 SHALL, in DATA, sample at each counter zero into a shift register and go to PARITY after the 8th bit.
REQ-021 SHALL, in PARITY, sample the parity bit and go to STOP.
REQ-022 SHALL, in STOP, sample the stop bit and return to IDLE on the same cycle; the next start edge is detected with no gap.
REQ-023 SHALL commit on the cycle after the stop sample: if full=0 or pop=1, load rdata, perr and ferr and set full=1.
REQ-024 SHALL, if the frame commits while full=1 and pop=0, set ovr=1 and leave rdata, perr, ferr and full unchanged.
REQ-025 SHALL clear full on pop when no commit occurs in that cycle; pop while full=0 is ignored.
REQ-026 SHALL, on clear, force IDLE and zero full, perr, ferr and ovr; rdata is retained; clear wins over a simultaneous commit.
REQ-027 SHALL sample div only on counter reload; a div change mid-bit takes effect at the next bit.

Reset
REQ-028 SHALL, on rst=1 at a rising clk edge, set state=IDLE, counter=0, rdata=0x00, full=0, perr=0, ferr=0, ovr=0, busy=0 and synchronizer=11.
REQ-029 SHALL discard a partially received frame when rst is asserted mid-frame.

Configuration
REQ-030 SHALL provide macro UART_RX_OS_PARITY_EN: when defined, the frame is 11 bits and the PARITY state is present.
REQ-031 SHALL, without UART_RX_OS_PARITY_EN, use a 10-bit frame, go DATA->STOP directly, and tie perr to 0.

Structure
REQ-032 SHALL place FSM state encodings, data width (8) and minimum period (4) in shared package uart_pkg.
REQ-033 SHALL place the bit counter (load, reload, zero strobe) in one sub-module, uart_bitcnt.

Verification
REQ-034 SHALL verify: div=16, byte 0xA5 with parity 0 -> rdata=0xA5, full=1, perr=0, ferr=0, with full rising about 170 clk after the start edge.
REQ-035 SHALL verify: div=16, byte 0x01 with parity bit forced 0 -> rdata=0x01, perr=1 (PARITY_EN build).
REQ-036 SHALL verify: div=16, byte 0x3C with stop bit forced 0 -> ferr=1, full=1.
REQ-037 SHALL verify: two frames 0x11 then 0x22 with no pop -> rdata=0x11, ovr=1; then pop -> full=0.
REQ-038 SHALL verify: 4-cycle low glitch on rx with div=16 -> busy returns 0, full=0.
REQ-039 SHALL verify: div=2 with 0x5A sent at a 4-clk period -> rdata=0x5A; rst mid-frame -> full=0 and rdata=0x00.
